// File: rtl/pc_stack.sv
// pc_stack: program counter with a hardware return-address stack.
// Q addresses instruction memory. Load jumps, Call pushes Q+1 and jumps,
// Ret pops into Q, Enable increments. Only one command acts per edge, in the
// order Load > Call > Ret > Enable. Err latches overflow and underflow until
// Reset or ClrErr.
// Build option PC_STACK_WRAP_EN: a Call on a full stack overwrites the oldest
// entry instead of flagging an error. The stack becomes circular.
module pc_stack #(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           D,
  input  logic                       Enable,
  input  logic                       Load,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic                       ClrErr,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // ptr points at the next slot to write. When the stack is full it also
  // points at the oldest entry, which is the slot a wrapping Call reuses.
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [PW-1:0]    ptr_inc, ptr_dec;
  logic             full, empty, err_set;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign ptr_inc = (ptr_q == LAST_PTR) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? LAST_PTR : ptr_q - PW'(1);

  // Select the single command for this edge and compute the next state.
  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    stack_d = stack_q;
    err_set = 1'b0;
    if (Load) begin
      q_d = D;
    end else if (Call) begin
      if (!full) begin
        stack_d[ptr_q] = q_q + WIDTH'(1);
        ptr_d          = ptr_inc;
        cnt_d          = cnt_q + CW'(1);
        q_d            = D;
      end else begin
`ifdef PC_STACK_WRAP_EN
        stack_d[ptr_q] = q_q + WIDTH'(1);
        ptr_d          = ptr_inc;
        q_d            = D;
`else
        err_set = 1'b1;
`endif
      end
    end else if (Ret) begin
      if (!empty) begin
        q_d   = stack_q[ptr_dec];
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CW'(1);
      end else begin
        err_set = 1'b1;
      end
    end else if (Enable) begin
      q_d = q_q + WIDTH'(1);
    end
    // A new error on the same edge as ClrErr must leave Err set.
    if (ClrErr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // PC, occupancy, pointer and error flag are cleared asynchronously.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q_q   <= RESET_ADDR;
      cnt_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Stack contents need no reset because Count guards every read.
  always_ff @(posedge Clock) begin
    stack_q <= stack_d;
  end

  assign Q     = q_q;
  assign Count = cnt_q;
  assign Full  = full;
  assign Empty = empty;
  assign Err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam logic [15:0] RESET_ADDR = 16'h0000;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] D;
  logic        Enable, Load, Call, Ret, ClrErr;
  logic [15:0] Q;
  logic [3:0]  Count;
  logic        Full, Empty, Err;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .Clock(Clock), .Reset(Reset), .D(D), .Enable(Enable), .Load(Load),
    .Call(Call), .Ret(Ret), .ClrErr(ClrErr), .Q(Q), .Count(Count),
    .Full(Full), .Empty(Empty), .Err(Err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] q;
    logic [3:0]  cnt;
    logic        full, empty, err;
    int          id;
  } exp_t;

  typedef struct {
    logic        ld, cl, rt, en, clr;
    logic [15:0] d;
    logic [15:0] q;
    logic [3:0]  cnt;
    logic        err;
  } vec_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // reference model: queue-based stack, back = top
  logic [15:0] m_q;
  logic [15:0] m_stk[$];
  logic        m_err;

  task automatic check_val(input string name, input int id,
                           input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
  endtask

  task automatic drive(input logic ld, cl, rt, en, clr, input logic [15:0] d);
    @(negedge Clock);
    Load = ld; Call = cl; Ret = rt; Enable = en; ClrErr = clr; D = d;
  endtask

  task automatic sample();
    exp_t e;
    @(posedge Clock);
    #1;
    Load = 0; Call = 0; Ret = 0; Enable = 0; ClrErr = 0;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      check_val("Q", e.id, 32'(Q), 32'(e.q));
      check_val("Count", e.id, 32'(Count), 32'(e.cnt));
      check_val("Full", e.id, 32'(Full), 32'(e.full));
      check_val("Empty", e.id, 32'(Empty), 32'(e.empty));
      check_val("Err", e.id, 32'(Err), 32'(e.err));
    end
  endtask

  task automatic model_reset();
    m_q = RESET_ADDR;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic ld, cl, rt, en, clr, input logic [15:0] d);
    logic err_new;
    err_new = 1'b0;
    if (ld) m_q = d;
    else if (cl) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(16'(m_q + 16'd1));
        m_q = d;
      end else begin
`ifdef PC_STACK_WRAP_EN
        void'(m_stk.pop_front());
        m_stk.push_back(16'(m_q + 16'd1));
        m_q = d;
`else
        err_new = 1'b1;
`endif
      end
    end else if (rt) begin
      if (m_stk.size() > 0) m_q = m_stk.pop_back();
      else err_new = 1'b1;
    end else if (en) m_q = 16'(m_q + 16'd1);
    if (clr) m_err = 1'b0;
    if (err_new) m_err = 1'b1;
  endtask

  task automatic step(input logic ld, cl, rt, en, clr, input logic [15:0] d, input int id);
    exp_t e;
    drive(ld, cl, rt, en, clr, d);
    model_step(ld, cl, rt, en, clr, d);
    e.q = m_q; e.cnt = 4'(m_stk.size());
    e.full = (m_stk.size() == DEPTH); e.empty = (m_stk.size() == 0);
    e.err = m_err; e.id = id;
    exp_q.push_back(e);
    sample();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    check_val("reset Q", 0, 32'(Q), 32'(RESET_ADDR));
    check_val("reset Count", 0, 32'(Count), 32'd0);
    check_val("reset Empty", 0, 32'(Empty), 32'd1);
    check_val("reset Full", 0, 32'(Full), 32'd0);
    check_val("reset Err", 0, 32'(Err), 32'd0);
  endtask

  function automatic vec_t mk(input logic ld, cl, rt, en, clr, input logic [15:0] d,
                              input logic [15:0] q, input logic [3:0] cnt, input logic err);
    vec_t v;
    v.ld = ld; v.cl = cl; v.rt = rt; v.en = en; v.clr = clr; v.d = d;
    v.q = q; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[15];
    exp_t e;
    //              ld cl rt en clr  D         Q         Cnt  Err
    vecs[0]  = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0001, 4'd0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0002, 4'd0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0003, 4'd0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 16'h0010, 16'h0010, 4'd0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0, 16'h0100, 16'h0100, 4'd1, 0);
    vecs[5]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0011, 4'd0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0011, 4'd0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0011, 4'd0, 0);
    vecs[8]  = mk(1, 1, 0, 1, 0, 16'h0042, 16'h0042, 4'd0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 4'd0, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 4'd0, 0);
    vecs[11] = mk(0, 1, 1, 0, 0, 16'h0300, 16'h0300, 4'd1, 0);
    vecs[12] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0001, 4'd0, 0);
    vecs[13] = mk(0, 0, 1, 0, 1, 16'h0000, 16'h0001, 4'd0, 1);
    vecs[14] = mk(0, 0, 0, 1, 1, 16'h0000, 16'h0002, 4'd0, 0);

    Reset = 1'b1; D = '0; Enable = 0; Load = 0; Call = 0; Ret = 0; ClrErr = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    check_val("reset Q", 0, 32'(Q), 32'(RESET_ADDR));
    check_val("reset Count", 0, 32'(Count), 32'd0);
    check_val("reset Empty", 0, 32'(Empty), 32'd1);
    check_val("reset Err", 0, 32'(Err), 32'd0);

    // directed table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ld, vecs[i].cl, vecs[i].rt, vecs[i].en, vecs[i].clr, vecs[i].d);
      e.q = vecs[i].q; e.cnt = vecs[i].cnt;
      e.full = (vecs[i].cnt == 4'd8); e.empty = (vecs[i].cnt == 4'd0);
      e.err = vecs[i].err; e.id = 100 + i;
      exp_q.push_back(e);
      sample();
    end

    // nested calls to full, one overflow call, then drain past empty
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 0, 0, 0, 16'(16'h1000 + i * 16'h10), 200 + i);
    step(0, 1, 0, 0, 0, 16'h0200, 208);
    for (int i = 0; i <= DEPTH; i++)
      step(0, 0, 1, 0, 0, 16'h0000, 210 + i);
    step(0, 0, 0, 0, 1, 16'h0000, 220);

    // random commands, including simultaneous ones
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 7) == 0, 16'($urandom), 1000 + i);

    // asynchronous reset between edges with three entries on the stack
    do_reset();
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 16'(16'h0500 + i), 300 + i);
    check_val("pre-reset Count", 303, 32'(Count), 32'd3);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_val("async Q", 304, 32'(Q), 32'(RESET_ADDR));
    check_val("async Count", 304, 32'(Count), 32'd0);
    check_val("async Empty", 304, 32'(Empty), 32'd1);
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    step(0, 0, 0, 1, 0, 16'h0000, 305);
    step(0, 0, 1, 0, 0, 16'h0000, 306);

    check_val("scoreboard drained", 999, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
